// File: rtl/imem_boot_loader_if.sv
// ---------------------------------------------------------------------------
// imem_boot_loader_if
//   Bundles the byte-stream input, the instruction-memory write port and the
//   status lines of the boot loader.
//   master : byte source / observer (drives rx_data, rx_valid)
//   slave  : the loader (accepts bytes, drives imem write and status)
//   Signals:
//     rx_data[7:0]     incoming byte
//     rx_valid         rx_data valid this cycle
//     rx_ready         loader can accept a byte
//     imem_we          instruction memory write strobe (one-cycle pulse)
//     imem_addr[15:0]  byte address of the write (always even)
//     imem_wdata[15:0] instruction word
//     cpu_reset        CPU reset, high until the image is loaded
//     busy             a frame is in progress
//     load_done        image loaded (sticky until reset)
//     load_error       frame rejected (sticky until the next sync byte)
// ---------------------------------------------------------------------------
interface imem_boot_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_reset;
    logic        busy;
    logic        load_done;
    logic        load_error;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, imem_we, imem_addr, imem_wdata,
        input  cpu_reset, busy, load_done, load_error
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, imem_we, imem_addr, imem_wdata,
        output cpu_reset, busy, load_done, load_error
    );
endinterface

// File: rtl/imem_boot_loader.sv
// ---------------------------------------------------------------------------
// imem_boot_loader
//   Receives a framed boot image as a byte stream and writes it as 16-bit
//   words into the CPU instruction memory, holding the CPU in reset until a
//   complete, valid image has been written.
//   Frame: SYNC_BYTE, LEN_HI, LEN_LO, N x (HI, LO) [, CHK]
//   Optional feature: define CHECKSUM_EN to require a trailing modulo-256
//   checksum byte covering LEN_HI, LEN_LO and every data byte.
//   Ports:
//     clk    clock
//     reset  asynchronous, active-high
//     bus    imem_boot_loader_if.slave (byte input, imem write, status)
//   All outputs are registered.
// ---------------------------------------------------------------------------
module imem_boot_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 256,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                clk,
    input  logic                reset,
    imem_boot_loader_if.slave   bus
);

    typedef enum logic [3:0] {
        S_SYNC, S_LEN_H, S_LEN_L, S_DAT_H, S_DAT_L, S_WR, S_CHK, S_DONE, S_ERROR
    } state_t;

    // 17 bits so a MAX_WORDS of 65536 still compares correctly against len
    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    // State that follows the final word (or an empty image)
`ifdef CHECKSUM_EN
    localparam state_t S_FIN = S_CHK;
`else
    localparam state_t S_FIN = S_DONE;
`endif

    state_t      state, next_state;
    logic [15:0] len;
    logic [15:0] k;
    logic        acc;
    logic [15:0] len_in;

    logic        rx_ready_d, imem_we_d, cpu_reset_d, busy_d, load_done_d, load_error_d;
    logic [15:0] addr_d;

    assign acc    = bus.rx_valid & bus.rx_ready;
    // Full length as seen in the LEN_L cycle, before it is latched
    assign len_in = {len[15:8], bus.rx_data};

`ifdef CHECKSUM_EN
    logic [7:0] sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum <= 8'h00;
        end else if (acc) begin
            case (state)
                S_SYNC, S_ERROR:                    sum <= 8'h00;
                S_LEN_H, S_LEN_L, S_DAT_H, S_DAT_L: sum <= sum + bus.rx_data;
                default:                            sum <= sum;
            endcase
        end
    end
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_SYNC;
        else       state <= next_state;
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_SYNC:  if (acc && bus.rx_data == SYNC_BYTE) next_state = S_LEN_H;
            S_LEN_H: if (acc) next_state = S_LEN_L;
            S_LEN_L: begin
                if (acc) begin
                    if ({1'b0, len_in} > MAX_W) next_state = S_ERROR;
                    else if (len_in == 16'd0)   next_state = S_FIN;
                    else                        next_state = S_DAT_H;
                end
            end
            S_DAT_H: if (acc) next_state = S_DAT_L;
            S_DAT_L: if (acc) next_state = S_WR;
            S_WR:    next_state = (k == len - 16'd1) ? S_FIN : S_DAT_H;
`ifdef CHECKSUM_EN
            S_CHK:   if (acc) next_state = (bus.rx_data == sum) ? S_DONE : S_ERROR;
`endif
            S_DONE:  next_state = S_DONE;
            S_ERROR: if (acc && bus.rx_data == SYNC_BYTE) next_state = S_LEN_H;
            default: next_state = S_SYNC;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line
    // up with the state they describe
    always_comb begin
        rx_ready_d   = !(next_state == S_WR || next_state == S_DONE);
        imem_we_d    = (next_state == S_WR);
        cpu_reset_d  = (next_state != S_DONE);
        busy_d       = !(next_state == S_SYNC || next_state == S_DONE ||
                         next_state == S_ERROR);
        load_done_d  = (next_state == S_DONE);
        load_error_d = (next_state == S_ERROR);
        addr_d       = BASE_ADDR + {k[14:0], 1'b0};
    end

    // Length and word-index tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len <= 16'h0000;
            k   <= 16'h0000;
        end else begin
            case (state)
                S_LEN_H: if (acc) len[15:8] <= bus.rx_data;
                S_LEN_L: if (acc) begin
                    len[7:0] <= bus.rx_data;
                    k        <= 16'h0000;
                end
                S_WR:    if (next_state == S_DAT_H) k <= k + 16'd1;
                default: ;
            endcase
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.rx_ready   <= 1'b1;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= BASE_ADDR;
            bus.imem_wdata <= 16'h0000;
            bus.cpu_reset  <= 1'b1;
            bus.busy       <= 1'b0;
            bus.load_done  <= 1'b0;
            bus.load_error <= 1'b0;
        end else begin
            bus.rx_ready   <= rx_ready_d;
            bus.imem_we    <= imem_we_d;
            bus.cpu_reset  <= cpu_reset_d;
            bus.busy       <= busy_d;
            bus.load_done  <= load_done_d;
            bus.load_error <= load_error_d;
            if (imem_we_d) bus.imem_addr <= addr_d;
            if (acc && state == S_DAT_H) bus.imem_wdata[15:8] <= bus.rx_data;
            if (acc && state == S_DAT_L) bus.imem_wdata[7:0]  <= bus.rx_data;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_boot_loader
//   Table-driven frames with hand-computed expected writes and status, plus
//   hand-written sequences for reset during WR, back-to-back bytes with
//   rx_valid held high, bytes offered after DONE, and (with CHECKSUM_EN)
//   a checksum mismatch.
// ---------------------------------------------------------------------------
module tb_imem_boot_loader;

`ifdef CHECKSUM_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    imem_boot_loader_if bif ();
    imem_boot_loader dut (.clk(clk), .reset(reset), .bus(bif));

    int checks = 0;
    int failures = 0;

    // Write monitor, sampled on the falling edge
    logic [31:0] wr_q[$];
    int          falls = 0;
    int          rdy_viol = 0;
    int          we_after_done = 0;
    logic        prev_cr = 1'b1;

    always @(negedge clk) begin
        if (bif.imem_we) begin
            wr_q.push_back({bif.imem_addr, bif.imem_wdata});
            if (bif.rx_ready)  rdy_viol++;
            if (bif.load_done) we_after_done++;
        end
        if (prev_cr && !bif.cpu_reset) falls++;
        prev_cr = bif.cpu_reset;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Offer one byte; returns at the falling edge after it was accepted.
    // rx_valid is left high so back-to-back bytes keep it asserted.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        bif.rx_data  = b;
        bif.rx_valid = 1'b1;
        for (int t = 0; t < 8 && !ok; t++) begin
            if (bif.rx_ready) ok = 1'b1;
            @(negedge clk);
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL rx_accept_timeout: byte %0h never accepted", b);
        end
    endtask

    task automatic apply_reset();
        bif.rx_valid = 1'b0;
        bif.rx_data  = 8'h00;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wr_q.delete();
        falls = 0;
    endtask

    typedef struct {
        logic [0:11][7:0] b;
        int               n;
        logic             has_chk;
        logic [7:0]       chk;
        int               nw;
        logic [0:3][15:0] w;
        logic             done;
        logic             err;
    } vec_t;

    vec_t vecs[6];

    initial begin
        // Plain 2-word image
        vecs[0] = '{b: {8'hA5,8'h00,8'h02,8'h12,8'h34,8'hAB,8'hCD,40'h0}, n: 7,
                    has_chk: 1'b1, chk: 8'hC0, nw: 2, w: {16'h1234,16'hABCD,32'h0},
                    done: 1'b1, err: 1'b0};
        // Junk before sync is discarded
        vecs[1] = '{b: {8'h00,8'hFF,8'h5A,8'hA5,8'h00,8'h01,8'hBE,8'hEF,32'h0}, n: 8,
                    has_chk: 1'b1, chk: 8'hAE, nw: 1, w: {16'hBEEF,48'h0},
                    done: 1'b1, err: 1'b0};
        // 257 words: one over the limit
        vecs[2] = '{b: {8'hA5,8'h01,8'h01,72'h0}, n: 3,
                    has_chk: 1'b0, chk: 8'h00, nw: 0, w: 64'h0,
                    done: 1'b0, err: 1'b1};
        // Error then a valid frame recovers
        vecs[3] = '{b: {8'hA5,8'h01,8'h01,8'hA5,8'h00,8'h01,8'h55,8'h66,32'h0}, n: 8,
                    has_chk: 1'b1, chk: 8'hBC, nw: 1, w: {16'h5566,48'h0},
                    done: 1'b1, err: 1'b0};
        // Empty image
        vecs[4] = '{b: {8'hA5,8'h00,8'h00,72'h0}, n: 3,
                    has_chk: 1'b1, chk: 8'h00, nw: 0, w: 64'h0,
                    done: 1'b1, err: 1'b0};
        // Huge length field
        vecs[5] = '{b: {8'hA5,8'h80,8'h00,72'h0}, n: 3,
                    has_chk: 1'b0, chk: 8'h00, nw: 0, w: 64'h0,
                    done: 1'b0, err: 1'b1};

        bif.rx_valid = 1'b0;
        bif.rx_data  = 8'h00;

        // Reset values
        @(negedge clk);
        check("rst_rx_ready",   32'(bif.rx_ready),   32'd1);
        check("rst_imem_we",    32'(bif.imem_we),    32'd0);
        check("rst_imem_addr",  32'(bif.imem_addr),  32'h0);
        check("rst_imem_wdata", 32'(bif.imem_wdata), 32'h0);
        check("rst_cpu_reset",  32'(bif.cpu_reset),  32'd1);
        check("rst_busy",       32'(bif.busy),       32'd0);
        check("rst_load_done",  32'(bif.load_done),  32'd0);
        check("rst_load_error", 32'(bif.load_error), 32'd0);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            apply_reset();
            for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].b[j]);
            if (CHK_ON && vecs[i].has_chk) send_byte(vecs[i].chk);
            bif.rx_valid = 1'b0;
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_nwrites", i), 32'(wr_q.size()), 32'(vecs[i].nw));
            for (int m = 0; m < vecs[i].nw && m < wr_q.size(); m++)
                check($sformatf("v%0d_write%0d", i, m), wr_q[m],
                      {16'(2 * m), vecs[i].w[m]});
            check($sformatf("v%0d_load_done", i),  32'(bif.load_done),  32'(vecs[i].done));
            check($sformatf("v%0d_load_error", i), 32'(bif.load_error), 32'(vecs[i].err));
            check($sformatf("v%0d_cpu_reset", i),  32'(bif.cpu_reset),  32'(!vecs[i].done));
            check($sformatf("v%0d_cr_falls", i),   32'(falls),          32'(vecs[i].done));
        end

`ifdef CHECKSUM_EN
        // Checksum mismatch: word written, then rejected
        apply_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        bif.rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("chk_err",       32'(bif.load_error), 32'd1);
        check("chk_cpu_reset", 32'(bif.cpu_reset),  32'd1);
        check("chk_nwrites",   32'(wr_q.size()),    32'd1);
        if (wr_q.size() > 0) check("chk_write0", wr_q[0], 32'h0000_0001);
`endif

        // Reset during the WR cycle of the third word
        apply_reset();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h11); send_byte(8'h11);
        send_byte(8'h22); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h33);
        check("wr3_imem_we",   32'(bif.imem_we),   32'd1);
        check("wr3_imem_addr", 32'(bif.imem_addr), 32'h4);
        bif.rx_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("arst_imem_we",   32'(bif.imem_we),   32'd0);
        check("arst_imem_addr", 32'(bif.imem_addr), 32'h0);
        check("arst_cpu_reset", 32'(bif.cpu_reset), 32'd1);
        check("arst_rx_ready",  32'(bif.rx_ready),  32'd1);
        check("arst_busy",      32'(bif.busy),      32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wr_q.delete();
        falls = 0;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h77); send_byte(8'h88);
        if (CHK_ON) send_byte(8'h00);
        bif.rx_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("reload_nwrites", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() > 0) check("reload_write0", wr_q[0], 32'h0000_7788);
        check("reload_done", 32'(bif.load_done), 32'd1);

        // rx_valid held high throughout, then bytes offered after DONE
        apply_reset();
        rdy_viol = 0;
        we_after_done = 0;
        send_byte(8'hA5);
        check("busy_midframe", 32'(bif.busy), 32'd1);
        send_byte(8'h00); send_byte(8'h03);
        send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h03); send_byte(8'h04);
        send_byte(8'h05); send_byte(8'h06);
        if (CHK_ON) send_byte(8'h18);
        bif.rx_data = 8'hA5;
        begin
            int rdy_seen = 0;
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (bif.rx_ready) rdy_seen++;
            end
            check("done_rx_ready_seen", 32'(rdy_seen), 32'd0);
        end
        bif.rx_valid = 1'b0;
        check("cont_nwrites", 32'(wr_q.size()), 32'd3);
        for (int m = 0; m < 3 && m < wr_q.size(); m++)
            check($sformatf("cont_write%0d", m), wr_q[m],
                  {16'(2 * m), 8'(2 * m + 1), 8'(2 * m + 2)});
        check("cont_rdy_in_wr",    32'(rdy_viol),      32'd0);
        check("cont_we_after_done", 32'(we_after_done), 32'd0);
        check("cont_done",         32'(bif.load_done), 32'd1);
        check("cont_busy",         32'(bif.busy),      32'd0);
        check("cont_cr_falls",     32'(falls),         32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
